vertex_feeder: RTL and testbench

VERTEX_FEEDER -- requirements
Module: vertex_feeder

---
 rtl/vertex_feeder.sv | 139 +++++++++++++
 tb/tb_vertex_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vertex_feeder.sv
// Nearest-vertex scanner: fetches each vertex from BRAM, hands it to the distance engine, tracks argmin.
// Optional FEEDER_TIMEOUT_EN adds a 64-cycle WAIT timeout that skips the vertex and raises timeout_err_out.
module vertex_feeder #(
    parameter int DIM       = 2,
    parameter int NUM_VERTS = 16,
    parameter int ADDR_W    = $clog2(NUM_VERTS*DIM)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic [DIM-1:0][31:0]       query_pos_in,
    output logic [ADDR_W-1:0]          mem_addr_out,
    input  logic [31:0]                mem_data_in,
    output logic [DIM-1:0][31:0]       vertex_pos_out,
    output logic [DIM-1:0][31:0]       query_pos_out,
    output logic [DIM-1:0]             data_valid_out,
    input  logic [31:0]                distance_sq_in,
    input  logic                       distance_valid_in,
    output logic [((NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1)-1:0] best_index_out,
    output logic [31:0]                best_dist_out,
`ifdef FEEDER_TIMEOUT_EN
    output logic                       timeout_err_out,
`endif
    output logic                       busy_out,
    output logic                       done_out
);
    localparam int IDX_W = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
    localparam int CNT_W = $clog2(DIM + 2) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] v;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             wait_exit;
`ifdef FEEDER_TIMEOUT_EN
    logic [5:0]       wait_cnt;
`endif

    always_comb begin
        timeout_hit = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        timeout_hit = (wait_cnt == 6'd63) && !distance_valid_in;
`endif
        wait_exit = (state == WAIT) && (distance_valid_in || timeout_hit);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            v              <= '0;
            cnt            <= '0;
            mem_addr_out   <= '0;
            vertex_pos_out <= '0;
            query_pos_out  <= '0;
            data_valid_out <= '0;
            best_dist_out  <= 32'hFFFF_FFFF;
            best_index_out <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            wait_cnt        <= '0;
            timeout_err_out <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: if (start_in) begin
                    state          <= FETCH;
                    query_pos_out  <= query_pos_in;
                    v              <= '0;
                    cnt            <= '0;
                    mem_addr_out   <= '0;
                    best_dist_out  <= 32'hFFFF_FFFF;
                    best_index_out <= '0;
                    busy_out       <= 1'b1;
`ifdef FEEDER_TIMEOUT_EN
                    timeout_err_out <= 1'b0;
`endif
                end
                FETCH: begin
                    // BRAM has two cycles of read latency: word k arrives in fetch cycle k+2
                    for (int k = 0; k < DIM; k++)
                        if (cnt == CNT_W'(k + 2)) vertex_pos_out[k] <= mem_data_in;
                    if (cnt < CNT_W'(DIM - 1)) mem_addr_out <= mem_addr_out + ADDR_W'(1);
                    if (cnt == CNT_W'(DIM + 1)) begin
                        state          <= ISSUE;
                        cnt            <= '0;
                        data_valid_out <= DIM'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (cnt == CNT_W'(DIM - 1)) begin
                        state          <= WAIT;
                        data_valid_out <= '0;
`ifdef FEEDER_TIMEOUT_EN
                        wait_cnt       <= '0;
`endif
                    end else begin
                        cnt            <= cnt + CNT_W'(1);
                        data_valid_out <= data_valid_out << 1;
                    end
                end
                WAIT: begin
                    if (wait_exit) begin
                        // strict compare keeps the lower index on ties; vertex 0 seeds the search
                        if (distance_valid_in && (v == '0 || distance_sq_in < best_dist_out)) begin
                            best_dist_out  <= distance_sq_in;
                            best_index_out <= v;
                        end
`ifdef FEEDER_TIMEOUT_EN
                        if (timeout_hit) timeout_err_out <= 1'b1;
`endif
                        if (v == IDX_W'(NUM_VERTS - 1)) begin
                            state    <= DONE;
                            busy_out <= 1'b0;
                            done_out <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            v            <= v + IDX_W'(1);
                            cnt          <= '0;
                            mem_addr_out <= ADDR_W'((int'(v) + 1) * DIM);
                        end
                    end
`ifdef FEEDER_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_feeder.sv
// Directed/random bench for vertex_feeder (DIM=2, NUM_VERTS=4) with a behavioural BRAM and argmin model.
module tb_vertex_feeder;
    localparam int DIM = 2;
    localparam int NV  = 4;
    localparam int AW  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [DIM-1:0][31:0] query_pos;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_data;
    logic [DIM-1:0][31:0] vertex_pos;
    logic [DIM-1:0][31:0] query_pos_q;
    logic [DIM-1:0]       data_valid;
    logic [31:0]          distance_sq;
    logic                 distance_valid;
    logic [1:0]           best_index;
    logic [31:0]          best_dist;
    logic                 busy;
    logic                 done;
`ifdef FEEDER_TIMEOUT_EN
    logic                 timeout_err;
`endif

    vertex_feeder #(.DIM(DIM), .NUM_VERTS(NV), .ADDR_W(AW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .query_pos_in(query_pos),
        .mem_addr_out(mem_addr), .mem_data_in(mem_data), .vertex_pos_out(vertex_pos),
        .query_pos_out(query_pos_q), .data_valid_out(data_valid),
        .distance_sq_in(distance_sq), .distance_valid_in(distance_valid),
        .best_index_out(best_index), .best_dist_out(best_dist),
`ifdef FEEDER_TIMEOUT_EN
        .timeout_err_out(timeout_err),
`endif
        .busy_out(busy), .done_out(done)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: data for an address appears two cycles later
    logic [31:0] mem [NV*DIM];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        pipe1    <= mem[mem_addr];
        mem_data <= pipe1;
    end

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] dists [NV];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_vpos", 64'(vertex_pos), 64'(0));
        chk("rst_qpos", 64'(query_pos_q), 64'(0));
        chk("rst_dv", 64'(data_valid), 64'(0));
        chk("rst_bdist", 64'(best_dist), 64'hFFFF_FFFF);
        chk("rst_bidx", 64'(best_index), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
`ifdef FEEDER_TIMEOUT_EN
        chk("rst_tmo", 64'(timeout_err), 64'(0));
`endif
    endtask

    // Argmin reference: vertex 0 seeds, later vertices win only when strictly smaller
    task automatic model(input int skip_v, output int bi, output logic [31:0] bd);
        bi = 0;
        bd = 32'hFFFF_FFFF;
        for (int i = 0; i < NV; i++)
            if (i != skip_v && (i == 0 || dists[i] < bd)) begin
                bd = dists[i];
                bi = i;
            end
    endtask

    task automatic run_scan(input int skip_v, input int start_wait_v, input int abort_v);
        int                   base;
        int                   ebi;
        logic [31:0]          ebd;
        logic [DIM-1:0][31:0] q;
        base = done_cnt;
        for (int i = 0; i < NV*DIM; i++) mem[i] = $urandom;
        q[0] = $urandom;
        q[1] = $urandom;
        @(negedge clk); start = 1'b1; query_pos = q;
        @(negedge clk); start = 1'b0;
        for (int v = 0; v < NV; v++) begin
            chk("addr_k0", 64'(mem_addr), 64'(v*2));
            chk("busy_fetch", 64'(busy), 64'(1));
            @(negedge clk);
            chk("addr_k1", 64'(mem_addr), 64'(v*2 + 1));
            @(negedge clk);
            distance_valid = 1'b1; distance_sq = 32'd0;   // must be ignored outside WAIT
            @(negedge clk);
            distance_valid = 1'b0;
            chk("dv_fetch", 64'(data_valid), 64'(0));
            @(negedge clk);
            chk("dv_issue0", 64'(data_valid), 64'(2'b01));
            chk("vpos0", 64'(vertex_pos[0]), 64'(mem[v*2]));
            chk("vpos1", 64'(vertex_pos[1]), 64'(mem[v*2 + 1]));
            chk("qpos", 64'(query_pos_q), 64'(q));
            if (abort_v == v) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals();
                @(negedge clk); rst_n = 1'b1;
                repeat (12) @(negedge clk);
                chk("no_done_after_rst", 64'(done_cnt - base), 64'(0));
                chk("idle_after_rst", 64'(busy), 64'(0));
                return;
            end
            @(negedge clk);
            chk("dv_issue1", 64'(data_valid), 64'(2'b10));
            @(negedge clk);
            chk("dv_wait", 64'(data_valid), 64'(0));
            chk("busy_wait", 64'(busy), 64'(1));
            if (skip_v == v) begin
`ifdef FEEDER_TIMEOUT_EN
                chk("tmo_before", 64'(timeout_err), 64'(0));
`endif
                repeat (64) @(negedge clk);
`ifdef FEEDER_TIMEOUT_EN
                chk("tmo_after", 64'(timeout_err), 64'(1));
`endif
            end else begin
                if (start_wait_v == v) begin
                    start = 1'b1;
                    @(negedge clk); start = 1'b0;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                distance_valid = 1'b1; distance_sq = dists[v];
                @(negedge clk);
                distance_valid = 1'b0;
            end
        end
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        @(negedge clk);
        chk("done_low", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        model(skip_v, ebi, ebd);
        chk("best_idx", 64'(best_index), 64'(ebi));
        chk("best_dist", 64'(best_dist), 64'(ebd));
        chk("done_count", 64'(done_cnt - base), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; query_pos = '0;
        distance_sq = '0; distance_valid = 1'b0;
        for (int i = 0; i < NV*DIM; i++) mem[i] = '0;
        #12;
        chk_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        dists[0] = 50; dists[1] = 20; dists[2] = 30; dists[3] = 20;
        run_scan(-1, -1, -1);
        chk("hold_idx", 64'(best_index), 64'(1));
        chk("hold_dist", 64'(best_dist), 64'(20));

        dists[0] = 32'hFFFF_FFFF; dists[1] = 32'hFFFF_FFFF;
        dists[2] = 32'hFFFF_FFFF; dists[3] = 32'hFFFF_FFFF;
        run_scan(-1, -1, -1);

        for (int i = 0; i < NV; i++) dists[i] = $urandom_range(0, 7);
        run_scan(-1, 2, -1);

        for (int i = 0; i < NV; i++) dists[i] = $urandom;
        run_scan(-1, -1, 1);
        run_scan(-1, -1, -1);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NV; i++) dists[i] = $urandom_range(0, 5) * 32'h1000_0000;
            run_scan(-1, -1, -1);
        end

`ifdef FEEDER_TIMEOUT_EN
        dists[0] = 40; dists[1] = 30; dists[2] = 5; dists[3] = 35;
        run_scan(2, -1, -1);
        chk("tmo_sticky", 64'(timeout_err), 64'(1));
        dists[0] = 9; dists[1] = 8; dists[2] = 7; dists[3] = 6;
        run_scan(-1, -1, -1);
        chk("tmo_cleared", 64'(timeout_err), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
